// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle shared by the two requesters, the data-memory arbiter and the RAM.
// Lock inputs exist only when DMEM_ARB_LOCK_EN is defined.
interface dmem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [DATA_W-1:0] mem_read_data_in;

`ifdef DMEM_ARB_LOCK_EN
  logic              m0_lock;
  logic              m1_lock;
`endif

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_address, mem_write_data, mem_write_enable, mem_read_enable,
    input  mem_read_data_in
`ifdef DMEM_ARB_LOCK_EN
    , input m0_lock, m1_lock
`endif
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_address, mem_write_data, mem_write_enable, mem_read_enable,
    output mem_read_data_in
`ifdef DMEM_ARB_LOCK_EN
    , output m0_lock, m1_lock
`endif
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter with burst limit sharing one single-port data RAM between the core (M0) and a loader (M1).
// Define DMEM_ARB_LOCK_EN to let the current owner lock out the other master.
module dmem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  dmem_bus_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_q, last_d;      // 1 = M1 was granted most recently
  logic             rvalid0_q, rvalid1_q;

  logic gnt0, gnt1;
  logic owner_m1, owner_lock, limit_hit;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    owner_m1  = (state_q == OWN1);
    limit_hit = (burst_cnt_q >= MAX_CNT);
`ifdef DMEM_ARB_LOCK_EN
    owner_lock = (state_q == OWN1) ? bus.m1_lock :
                 (state_q == OWN0) ? bus.m0_lock : 1'b0;
`else
    owner_lock = 1'b0;
`endif
    if (bus.m0_req && bus.m1_req) begin
      if (state_q == IDLE) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else if (!limit_hit || owner_lock) begin
        gnt0 = ~owner_m1;
        gnt1 = owner_m1;
      end else begin
        gnt0 = owner_m1;
        gnt1 = ~owner_m1;
      end
    end else begin
      gnt0 = bus.m0_req;
      gnt1 = bus.m1_req;
    end
  end

  always_comb begin
    state_d     = IDLE;
    burst_cnt_d = '0;
    last_d      = last_q;
    if (gnt0 || gnt1) begin
      state_d = gnt1 ? OWN1 : OWN0;
      last_d  = gnt1;
      if (state_q == state_d)
        burst_cnt_d = limit_hit ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
      else
        burst_cnt_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_q      <= 1'b1;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      rvalid0_q   <= gnt0 & ~bus.m0_we;
      rvalid1_q   <= gnt1 & ~bus.m1_we;
    end
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;

  assign bus.mem_address      = gnt1 ? bus.m1_addr  : (gnt0 ? bus.m0_addr  : '0);
  assign bus.mem_write_data   = gnt1 ? bus.m1_wdata : (gnt0 ? bus.m0_wdata : '0);
  assign bus.mem_write_enable = (gnt0 & bus.m0_we)  | (gnt1 & bus.m1_we);
  assign bus.mem_read_enable  = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);

  // RAM output is already registered, so returned data is steered rather than re-registered.
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rvalid0_q ? bus.mem_read_data_in : '0;
  assign bus.m1_rdata  = rvalid1_q ? bus.mem_read_data_in : '0;

`ifndef SYNTHESIS
  m0_req_held: assert property (@(posedge clk) disable iff (reset)
    (bus.m0_req && !bus.m0_gnt) |=> bus.m0_req);
  m1_req_held: assert property (@(posedge clk) disable iff (reset)
    (bus.m1_req && !bus.m1_gnt) |=> bus.m1_req);
`endif
endmodule
